// File: rtl/jtsdram_bankchk_if.sv
// jtsdram_bankchk_if: SDRAM request/response bus between the bank checker and the memory controller
interface jtsdram_bankchk_if #(parameter int AW = 22, parameter int DW = 16);
   logic [AW-1:0]   addr;
   logic            rd, wr, ack, rdy;
   logic [DW-1:0]   din, dout;
   logic [DW/8-1:0] din_m;
   modport master(output addr, rd, wr, din, din_m, input ack, rdy, dout);
   modport slave(input addr, rd, wr, din, din_m, output ack, rdy, dout);
endinterface

// File: rtl/jtsdram_bankchk.sv
// jtsdram_bankchk: writes an LFSR pattern over a word range, reads it back and reports errors/timeouts
module jtsdram_bankchk #(
   parameter int AW = 22,
   parameter int DW = 16,
   parameter int NWORDS = 1024,
   parameter logic [AW-1:0] BASE = '0,
   parameter int WRMODE = 1,
   parameter logic [15:0] SEED = 16'hACE1,
   parameter int TMO = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           bad,
   output logic           timeout,
   output logic [15:0]    err_cnt,
   output logic [AW-1:0]  fail_addr,
   jtsdram_bankchk_if.master bus
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} st_t;
   st_t st, st_nxt;
   logic [15:0] lfsr, tmr;
   logic [AW:0] cnt;
   logic [DW-1:0] pat;
   logic wait_st, tmo, wdone, err, last, fb, wr_end;
   assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign pat     = DW == 32 ? DW'({lfsr, ~lfsr}) : DW'(lfsr);
   assign wait_st = st == WR_WAIT || st == RD_WAIT;
   assign tmo     = wait_st && !bus.rdy && tmr == 16'(TMO - 1);
   assign wdone   = wait_st && (bus.rdy || tmo);
   assign err     = tmo || (st == RD_WAIT && bus.rdy && bus.dout != pat);
   assign last    = cnt == (AW+1)'(NWORDS - 1);
   assign wr_end  = st == WR_WAIT && last;
   assign busy    = st != IDLE && st != DONE;
   assign done    = st == DONE;
   assign bus.rd  = st == RD_REQ;
   assign bus.wr  = st == WR_REQ;
   assign bus.din   = bus.wr ? pat : '0;
   assign bus.din_m = bus.wr ? '0 : '1;
   always_ff @(posedge clk or negedge rst)
      if (!rst) st <= IDLE;
      else st <= st_nxt;
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (start) st_nxt = WRMODE != 0 ? WR_REQ : RD_REQ;
         WR_REQ:  if (bus.ack) st_nxt = WR_WAIT;
         WR_WAIT: if (wdone) st_nxt = last ? RD_REQ : WR_REQ;
         RD_REQ:  if (bus.ack) st_nxt = RD_WAIT;
         RD_WAIT: if (wdone) st_nxt = last ? DONE : RD_REQ;
         default: st_nxt = IDLE;
      endcase
   end
   // a timed-out word counts as an error and still advances the pass
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.addr  <= BASE;
         lfsr      <= SEED;
         cnt       <= '0;
         tmr       <= '0;
         bad       <= 1'b0;
         timeout   <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
      end else begin
         tmr <= wait_st ? tmr + 16'd1 : 16'd0;
         if (st == IDLE && start) begin
            bus.addr  <= BASE;
            lfsr      <= SEED;
            cnt       <= '0;
            bad       <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
         end
         if (err) begin
            bad     <= 1'b1;
            err_cnt <= err_cnt + 16'(err_cnt != 16'hFFFF);
            if (!bad) fail_addr <= bus.addr;
         end
         if (tmo) timeout <= 1'b1;
         if (wdone) begin
            cnt      <= last ? '0 : cnt + (AW+1)'(1);
            bus.addr <= wr_end ? BASE : bus.addr + AW'(1);
            lfsr     <= wr_end ? SEED : {lfsr[14:0], fb};
         end
      end
   end
endmodule

// File: tb/tb_jtsdram_bankchk.sv
// tb_jtsdram_bankchk: three checker configurations against a scoreboarded SDRAM model
module tb_jtsdram_bankchk;
   typedef struct packed {logic w; logic [21:0] a; logic [31:0] d;} acc_t;
   function automatic int nw_of(int i); return i == 1 ? 4 : 16; endfunction
   function automatic logic [21:0] base_of(int i); return i == 1 ? 22'h3FFFFE : 22'h40; endfunction
   function automatic int wm_of(int i); return i == 2 ? 0 : 1; endfunction
   function automatic int dw_of(int i); return i == 1 ? 32 : 16; endfunction
   function automatic logic [15:0] nxt(logic [15:0] l); return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]}; endfunction
   function automatic logic [31:0] pat_of(int i, logic [15:0] l); return dw_of(i) == 32 ? {l, ~l} : {16'h0, l}; endfunction
   logic clk = 0, rst = 1;
   logic start[3], busy[3], done[3], bad[3], timeout[3];
   logic [15:0] err_cnt[3];
   logic [21:0] fail_addr[3];
   logic [31:0] mem[int];
   acc_t exp_q[$];
   int total = 0, nbad = 0, reqs = 0;
   int c0 = -1, c1 = -1, hold_a = -1;
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask
   for (genvar i = 0; i < 3; i++) begin : g
      localparam int DWI = dw_of(i);
      jtsdram_bankchk_if #(.AW(22), .DW(DWI)) b();
      jtsdram_bankchk #(.AW(22), .DW(DWI), .NWORDS(nw_of(i)), .BASE(base_of(i)), .WRMODE(wm_of(i)), .SEED(16'hACE1), .TMO(8)) dut (
         .clk(clk), .rst(rst), .start(start[i]), .busy(busy[i]), .done(done[i]), .bad(bad[i]),
         .timeout(timeout[i]), .err_cnt(err_cnt[i]), .fail_addr(fail_addr[i]), .bus(b));
      acc_t e;
      int ph = 0, dly = 0;
      logic pend = 0, w = 0;
      logic [21:0] a = '0, pa = '0;
      logic [31:0] rdat;
      initial begin
         b.ack = 0;
         b.rdy = 0;
         b.dout = '0;
      end
      // memory model: random ack latency, rdy 1..3 cycles after ack
      always @(negedge clk) begin
         b.ack = 0;
         b.rdy = 0;
         if (b.rd || b.wr) reqs++;
         if (!rst) begin
            ph = 0;
            pend = 0;
         end else if (ph == 0 && (b.rd || b.wr)) begin
            if (!pend) pa = b.addr;
            pend = 1;
            if ($urandom_range(0, 2) != 0) begin
               chk("excl", 64'(b.rd & b.wr), 0);
               chk("addr_hold", 64'(b.addr), 64'(pa));
               chk("q_empty", 64'(exp_q.size() == 0), 0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("op", 64'(b.wr), 64'(e.w));
                  chk("addr", 64'(b.addr), 64'(e.a));
                  if (b.wr) begin
                     chk("din", 64'(b.din), 64'(e.d));
                     chk("mask", 64'(b.din_m), 0);
                  end
               end
               w = b.wr;
               a = b.addr;
               pend = 0;
               if (w) mem[int'(a)] = 32'(b.din);
               b.ack = 1;
               ph = 1;
               dly = int'($urandom_range(1, 3));
            end
         end else if (ph == 1) begin
            dly--;
            if (dly == 0) begin
               ph = 0;
               rdat = mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
               if (i == 0 && !w && (int'(a) == c0 || int'(a) == c1)) rdat ^= 32'h1;
               b.dout = DWI'(rdat);
               b.rdy = w || !(i == 0 && int'(a) == hold_a);
            end
         end
      end
   end
   task automatic push_exp(int i);
      logic [15:0] l;
      for (int p = wm_of(i) != 0 ? 0 : 1; p < 2; p++) begin
         l = 16'hACE1;
         for (int k = 0; k < nw_of(i); k++) begin
            exp_q.push_back('{w: p == 0, a: base_of(i) + 22'(k), d: pat_of(i, l)});
            l = nxt(l);
         end
      end
   endtask
   task automatic run(int i, bit again, int ebad, int ecnt, int efa, int eto);
      int n = 0;
      exp_q.delete();
      push_exp(i);
      @(negedge clk) start[i] = 1;
      @(negedge clk) start[i] = 0;
      chk("busy", 64'(busy[i]), 1);
      while (!done[i] && n < 3000) begin
         @(negedge clk);
         start[i] = again && n == 10;
         n++;
      end
      start[i] = 0;
      chk("done", 64'(done[i]), 1);
      chk("busy_at_done", 64'(busy[i]), 0);
      repeat (6) @(negedge clk);
      chk("q_left", 64'(exp_q.size()), 0);
      chk("idle", 64'(busy[i]), 0);
      chk("bad", 64'(bad[i]), 64'(ebad));
      chk("err_cnt", 64'(err_cnt[i]), 64'(ecnt));
      chk("fail_addr", 64'(fail_addr[i]), 64'(efa));
      chk("timeout", 64'(timeout[i]), 64'(eto));
   endtask
   task automatic chk_rst(string tag);
      chk({tag, "_busy"}, 64'(busy[0]), 0);
      chk({tag, "_done"}, 64'(done[0]), 0);
      chk({tag, "_rd"}, 64'(g[0].b.rd), 0);
      chk({tag, "_wr"}, 64'(g[0].b.wr), 0);
      chk({tag, "_addr"}, 64'(g[0].b.addr), 64'h40);
      chk({tag, "_din"}, 64'(g[0].b.din), 0);
      chk({tag, "_din_m"}, 64'(g[0].b.din_m), 64'h3);
      chk({tag, "_bad"}, 64'(bad[0]), 0);
      chk({tag, "_errs"}, 64'(err_cnt[0]), 0);
      chk({tag, "_fa"}, 64'(fail_addr[0]), 0);
      chk({tag, "_tmo"}, 64'(timeout[0]), 0);
   endtask
   initial begin
      int n;
      logic [15:0] l;
      for (int k = 0; k < 3; k++) start[k] = 0;
      #1 rst = 0;
      repeat (3) @(negedge clk);
      chk_rst("rst");
      rst = 1;
      run(0, 0, 0, 0, 0, 0);
      c0 = 'h45;
      c1 = 'h49;
      run(0, 0, 1, 2, 'h45, 0);
      c0 = -1;
      c1 = -1;
      hold_a = 'h43;
      run(0, 0, 1, 1, 'h43, 1);
      hold_a = -1;
      run(1, 0, 0, 0, 0, 0);
      // reset while word 7 is being written
      exp_q.delete();
      push_exp(0);
      @(negedge clk) start[0] = 1;
      @(negedge clk) start[0] = 0;
      n = 0;
      while (!(g[0].b.wr && g[0].b.addr == 22'h47) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("w7_seen", 64'(g[0].b.wr && g[0].b.addr == 22'h47), 1);
      #2 rst = 0;
      #1 chk_rst("midrst");
      exp_q.delete();
      repeat (5) @(negedge clk);
      rst = 1;
      reqs = 0;
      repeat (20) @(negedge clk);
      chk("no_req", 64'(reqs), 0);
      run(0, 0, 0, 0, 0, 0);
      // read-only pass over freshly preloaded memory
      mem.delete();
      l = 16'hACE1;
      for (int k = 0; k < 16; k++) begin
         mem['h40 + k] = {16'h0, l};
         l = nxt(l);
      end
      run(2, 1, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end
endmodule

// File: doc/jtsdram_bankchk.md
JTSDRAM_BANKCHK -- requirements
Module: jtsdram_bankchk

Interface
REQ-001 SHALL provide parameter AW, default 22: word address width.
REQ-002 SHALL provide parameter DW, default 16: data width; legal values 16 or 32 only.
REQ-003 SHALL provide parameter NWORDS, default 1024: words tested per pass, range 1..2^AW.
REQ-004 SHALL provide parameter BASE, default 0: first tested word address.
REQ-005 SHALL provide parameter WRMODE, default 1: 1 = write pass then read pass; 0 = read pass only.
REQ-006 SHALL provide parameter SEED, default 16'hACE1: LFSR seed, nonzero.
REQ-007 SHALL provide parameter TMO, default 255: maximum cycles from ack to rdy.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: begin a test, sampled only in IDLE.
REQ-011 SHALL have port busy, output, 1 bit: test in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at test end.
REQ-013 SHALL have port addr, output, AW bits: SDRAM word address.
REQ-014 SHALL have port rd, output, 1 bit: read request.
REQ-015 SHALL have port wr, output, 1 bit: write request.
REQ-016 SHALL have port din, output, DW bits: write data.
REQ-017 SHALL have port din_m, output, DW/8 bits: write byte mask, active-high masks the byte.
REQ-018 SHALL have port ack, input, 1 bit: request accepted.
REQ-019 SHALL have port rdy, input, 1 bit: access complete, read data valid.
REQ-020 SHALL have port dout, input, DW bits: read data.
REQ-021 SHALL have port bad, output, 1 bit: sticky, high when any error occurred in the current/last test.
REQ-022 SHALL have port err_cnt, output, 16 bits: saturating error count.
REQ-023 SHALL have port fail_addr, output, AW bits: address of the first error.
REQ-024 SHALL have port timeout, output, 1 bit: sticky, high when any rdy timeout occurred.

Function
REQ-025 SHALL implement the FSM IDLE -> WR_REQ -> WR_WAIT -> ... -> RD_REQ -> RD_WAIT -> ... -> DONE -> IDLE; with WRMODE=0, IDLE goes directly to RD_REQ.
REQ-026 On start in IDLE, SHALL set addr=BASE, load LFSR=SEED, clear bad, err_cnt, fail_addr and timeout, and assert busy the next cycle.
REQ-027 SHALL generate the pattern with a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing once per completed word; the reference equals lfsr when DW=16 and {lfsr,~lfsr} when DW=32.
REQ-028 In WR_REQ, SHALL hold wr=1, din=reference and din_m=0 until ack; the cycle after ack, wr=0 and the FSM enters WR_WAIT.
REQ-029 In RD_REQ, SHALL hold rd=1 until ack; the cycle after ack, rd=0 and the FSM enters RD_WAIT.
REQ-030 rd and wr SHALL never be high together; addr SHALL stay stable while a request is pending.
REQ-031 In RD_WAIT, on rdy SHALL compare dout with the reference; on mismatch, increment err_cnt (saturating at 16'hFFFF) and set bad; on the first error, also latch fail_addr=addr.
REQ-032 A wait state SHALL count cycles from entry; if rdy has not arrived after TMO cycles, SHALL set timeout and bad, increment err_cnt (latching fail_addr if first), and treat the word as complete.
REQ-033 On word completion, SHALL increment addr modulo 2^AW (wraps past all-ones) and advance the LFSR; after NWORDS words, the write pass SHALL reload addr=BASE and LFSR=SEED and enter RD_REQ, and the read pass SHALL enter DONE.
REQ-034 DONE SHALL last one cycle with done=1 and busy=0 the same cycle; results SHALL hold until the next start.
REQ-035 start outside IDLE SHALL be ignored; ack or rdy in a state that does not expect it SHALL be ignored.
REQ-036 rdy arriving in the same cycle as ack SHALL not be used; only rdy seen in a wait state is valid.

Reset
REQ-037 When rst=0, SHALL immediately enter IDLE with busy=done=rd=wr=0, addr=BASE, din=0, din_m=all ones, bad=timeout=0, err_cnt=0 and fail_addr=0, including in the middle of a test; no pending request SHALL resume after reset is released.

Verification
REQ-038 Ideal SDRAM model, NWORDS=16, WRMODE=1, start pulse -> 16 writes then 16 reads at BASE..BASE+15, done pulse, bad=0, err_cnt=0.
REQ-039 Model corrupts bit 0 of the read at BASE+5 and BASE+9 -> err_cnt=2, fail_addr=BASE+5, bad=1, timeout=0.
REQ-040 Model withholds rdy for the read at BASE+3, TMO=8 -> timeout=1, err_cnt=1, fail_addr=BASE+3, the test still completes with a done pulse.
REQ-041 BASE=2^AW-2, NWORDS=4 -> addresses 3FFFFE, 3FFFFF, 000000, 000001 in both passes.
REQ-042 rst driven low during the write of word 7, then released -> all outputs at reset values, no rd/wr until the next start; a new start runs a full clean test.
REQ-043 WRMODE=0 against preloaded memory; start pulsed again while busy -> read-only pass, the second start is ignored, exactly NWORDS reads occur.
